// File: rtl/squeeze_output_buffer_if.sv
// Handshake bundle between the permute FSM / downstream consumer and the squeeze output buffer.
interface squeeze_output_buffer_if #(
    parameter int unsigned MAX_RATE_BITS = 1344,
    parameter int unsigned WORD_BITS     = 64
);
    logic [MAX_RATE_BITS-1:0] block_in;
    logic                     block_we;
    logic                     block_last;
    logic [4:0]               block_words;
    logic                     available_clr;
    logic                     available;
    logic [WORD_BITS-1:0]     dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic                     dout_last;
    logic                     overflow;

    modport master (
        output block_in, block_we, block_last, block_words, available_clr, dout_ready,
        input  available, dout, dout_valid, dout_last, overflow
    );

    modport slave (
        input  block_in, block_we, block_last, block_words, available_clr, dout_ready,
        output available, dout, dout_valid, dout_last, overflow
    );
endinterface

// File: rtl/squeeze_output_buffer.sv
// Captures one rate-sized squeezed block in a single write and streams it out as
// WORD_BITS words on a valid/ready port, flagging writes that arrive while busy.
module squeeze_output_buffer #(
    parameter int unsigned MAX_RATE_BITS = 1344,
    parameter int unsigned WORD_BITS     = 64
) (
    input logic                    clk,
    input logic                    rst,
    squeeze_output_buffer_if.slave bus
);
    localparam int unsigned MAX_WORDS = MAX_RATE_BITS / WORD_BITS;

    typedef enum logic {EMPTY, STREAM} state_t;

    state_t               r_state;
    logic [WORD_BITS-1:0] r_words [MAX_WORDS];
    logic [4:0]           r_count;
    logic [4:0]           r_idx;
    logic                 r_last;
    logic                 r_available;
    logic                 r_dout_valid;
    logic                 r_dout_last;
    logic [WORD_BITS-1:0] r_dout;
    logic                 r_overflow;

    logic [4:0] w_words;
    logic [4:0] w_next_idx;
    logic       w_accept;
    logic       w_load;
    logic       w_hs;
    logic       w_final;

    assign w_words    = (bus.block_words > 5'(MAX_WORDS)) ? 5'(MAX_WORDS) : bus.block_words;
    assign w_next_idx = r_idx + 5'd1;
    assign w_accept   = bus.block_we && (r_state == EMPTY) && r_available;
    assign w_load     = w_accept && (w_words != 5'd0);
    assign w_hs       = r_dout_valid && bus.dout_ready;
    assign w_final    = w_hs && (r_idx == r_count - 5'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= EMPTY;
            r_count      <= '0;
            r_idx        <= '0;
            r_last       <= 1'b0;
            r_available  <= 1'b1;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_dout       <= '0;
            r_overflow   <= 1'b0;
            for (int unsigned k = 0; k < MAX_WORDS; k++) begin
                r_words[k] <= '0;
            end
        end else begin
            if (bus.block_we && !w_accept) begin
                r_overflow <= 1'b1;
            end

            // clr beats both the final-handshake set and the idle re-arm
            if (bus.available_clr || w_load) begin
                r_available <= 1'b0;
            end else if (w_final || (r_state == EMPTY)) begin
                r_available <= 1'b1;
            end

            case (r_state)
                EMPTY: begin
                    if (w_load) begin
                        for (int unsigned k = 0; k < MAX_WORDS; k++) begin
                            r_words[k] <= bus.block_in[k*WORD_BITS +: WORD_BITS];
                        end
                        r_count      <= w_words;
                        r_last       <= bus.block_last;
                        r_idx        <= '0;
                        r_dout       <= bus.block_in[WORD_BITS-1:0];
                        r_dout_last  <= bus.block_last && (w_words == 5'd1);
                        r_dout_valid <= 1'b1;
                        r_state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_final) begin
                        r_dout_valid <= 1'b0;
                        r_dout_last  <= 1'b0;
                        r_state      <= EMPTY;
                    end else if (w_hs) begin
                        r_idx       <= w_next_idx;
                        r_dout      <= r_words[w_next_idx];
                        r_dout_last <= r_last && (w_next_idx == r_count - 5'd1);
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign bus.available  = r_available;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_last  = r_dout_last;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_squeeze_output_buffer.sv
// Scoreboard bench: writes push expected words, a negedge monitor pops and compares on each handshake.
module tb_squeeze_output_buffer;
    localparam int unsigned RB = 1344;
    localparam int unsigned WB = 64;
    localparam int MW = 21;

    typedef struct {
        logic [63:0] data;
        logic        last;
        bit          fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    squeeze_output_buffer_if #(.MAX_RATE_BITS(RB), .WORD_BITS(WB)) bus ();
    squeeze_output_buffer #(.MAX_RATE_BITS(RB), .WORD_BITS(WB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        q[$];
    int          n_checks    = 0;
    int          n_pass      = 0;
    int unsigned cyc         = 0;
    int          last_hs_cyc = -1;
    int          n_pop       = 0;
    int          rdy_mode    = 1;
    logic        man_ready   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: a block is just its first min(n,21) words; only the very last word of a final block is tagged.
    function automatic void model_push(input logic [RB-1:0] data, input int n, input logic lst);
        int nn;
        exp_t e;
        nn = (n > MW) ? MW : n;
        for (int k = 0; k < nn; k++) begin
            e.data = data[k*WB +: WB];
            e.last = lst && (k == nn - 1);
            e.fin  = (k == nn - 1);
            q.push_back(e);
        end
    endfunction

    function automatic logic [RB-1:0] mk_seq();
        logic [RB-1:0] b;
        for (int k = 0; k < MW; k++) b[k*WB +: WB] = 64'(k + 1);
        return b;
    endfunction

    function automatic logic [RB-1:0] mk_rand();
        logic [RB-1:0] b;
        for (int k = 0; k < MW; k++) b[k*WB +: WB] = {$urandom, $urandom};
        return b;
    endfunction

    // dout_ready source; updates at posedge+2 so it is stable at the negedge sample and next edge
    initial begin
        int ph;
        ph = 0;
        bus.dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: bus.dout_ready = man_ready;
                1: bus.dout_ready = 1'b1;
                2: begin
                    bus.dout_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                default: bus.dout_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: stability under backpressure and in-order delivery against the queue
    initial begin
        logic        pv, pr, pl;
        logic [63:0] pd;
        exp_t        e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 64'(bus.dout_valid), 64'd1);
                    chk("hold_dout", bus.dout, pd);
                    chk("hold_last", 64'(bus.dout_last), 64'(pl));
                end
                if (bus.dout_valid) begin
                    chk("word_expected", 64'(q.size() != 0), 64'd1);
                    if (bus.dout_ready && q.size() != 0) begin
                        e = q.pop_front();
                        chk("dout", bus.dout, e.data);
                        chk("dout_last", 64'(bus.dout_last), 64'(e.last));
                        n_pop++;
                        if (e.fin) last_hs_cyc = int'(cyc);
                    end
                end
                pv = bus.dout_valid; pr = bus.dout_ready; pd = bus.dout; pl = bus.dout_last;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; the write is sampled on the next edge
    task automatic do_write(input logic [RB-1:0] data, input int n, input logic lst, input bit accept);
        bus.block_in    = data;
        bus.block_words = 5'(n);
        bus.block_last  = lst;
        bus.block_we    = 1'b1;
        if (accept) model_push(data, n, lst);
        step();
        bus.block_we = 1'b0;
        if (accept && n != 0) begin
            chk("first_valid_latency", 64'(bus.dout_valid), 64'd1);
            chk("avail_low_on_load", 64'(bus.available), 64'd0);
        end else if (accept) begin
            chk("zero_len_no_valid", 64'(bus.dout_valid), 64'd0);
            chk("zero_len_avail", 64'(bus.available), 64'd1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (!(q.size() == 0 && bus.available) && t < 3000) begin
            step();
            t++;
        end
        chk("drain_timeout", 64'(t < 3000), 64'd1);
        chk("avail_rise_cycle", 64'(cyc), 64'(last_hs_cyc + 1));
        chk("bubble_no_valid", 64'(bus.dout_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, start, t, nv;
        rst = 1'b0;
        bus.block_in = '0; bus.block_we = 1'b0; bus.block_last = 1'b0;
        bus.block_words = '0; bus.available_clr = 1'b0;
        repeat (3) step();
        chk("rst_available", 64'(bus.available), 64'd1);
        chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
        chk("rst_dout_last", 64'(bus.dout_last), 64'd0);
        chk("rst_dout", bus.dout, 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        rst = 1'b1;
        step();

        rdy_mode = 1;
        do_write(mk_seq(), 17, 1'b0, 1'b1);
        wait_drain();
        do_write(mk_rand(), 4, 1'b1, 1'b1);
        wait_drain();

        rdy_mode = 2;
        do_write(mk_rand(), 21, 1'b0, 1'b1);
        wait_drain();

        // wait_drain returns on the cycle available rises, so these writes are back-to-back
        rdy_mode = 1;
        do_write(mk_rand(), 21, 1'b0, 1'b1);
        wait_drain();
        do_write(mk_rand(), 17, 1'b1, 1'b1);
        wait_drain();

        rdy_mode = 3;
        for (int i = 0; i < 12; i++) begin
            n = $urandom_range(0, 31);
            if (i == 0) n = 0;
            if (i == 1) n = 31;
            do_write(mk_rand(), n, 1'($urandom_range(0, 1)), 1'b1);
            if (n != 0) wait_drain();
        end

        bus.available_clr = 1'b1;
        step();
        bus.available_clr = 1'b0;
        chk("clr_idle_avail_low", 64'(bus.available), 64'd0);
        chk("clr_idle_no_valid", 64'(bus.dout_valid), 64'd0);
        step();
        chk("clr_idle_avail_back", 64'(bus.available), 64'd1);

        rdy_mode = 0;
        man_ready = 1'b0;
        do_write(mk_seq(), 1, 1'b1, 1'b1);
        step();
        step();
        chk("stall_valid", 64'(bus.dout_valid), 64'd1);
        man_ready = 1'b1;
        bus.available_clr = 1'b1;
        step();
        man_ready = 1'b0;
        bus.available_clr = 1'b0;
        chk("clr_wins_avail", 64'(bus.available), 64'd0);
        chk("clr_final_no_valid", 64'(bus.dout_valid), 64'd0);
        step();
        chk("clr_final_avail_back", 64'(bus.available), 64'd1);
        chk("no_overflow_yet", 64'(bus.overflow), 64'd0);

        rdy_mode = 3;
        do_write(mk_rand(), 21, 1'b0, 1'b1);
        step();
        do_write(mk_rand(), 21, 1'b1, 1'b0);
        chk("overflow_set", 64'(bus.overflow), 64'd1);
        wait_drain();
        chk("overflow_sticky", 64'(bus.overflow), 64'd1);

        bus.available_clr = 1'b1;
        step();
        bus.available_clr = 1'b0;
        do_write(mk_rand(), 5, 1'b0, 1'b0);
        chk("write_while_unavail_ignored", 64'(bus.dout_valid), 64'd0);
        step();

        rdy_mode = 1;
        start = n_pop;
        do_write(mk_rand(), 21, 1'b1, 1'b1);
        t = 0;
        while (n_pop - start < 7 && t < 100) begin
            step();
            t++;
        end
        chk("reach_word8", 64'(n_pop - start), 64'd7);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.dout_valid), 64'd0);
        chk("async_rst_avail", 64'(bus.available), 64'd1);
        chk("async_rst_dout", bus.dout, 64'd0);
        chk("async_rst_overflow", 64'(bus.overflow), 64'd0);
        q.delete();
        repeat (3) step();
        rst = 1'b1;
        nv = 0;
        repeat (10) begin
            step();
            if (bus.dout_valid) nv++;
        end
        chk("no_output_after_reset", 64'(nv), 64'd0);
        chk("avail_after_reset", 64'(bus.available), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
